// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: serial load, CAP_CYCLES capture edges, serial unload.
// Optional compare against EXPECT/MASK when SCAN_CHAIN_CTRL_COMPARE_EN is defined.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN  = 32,
  parameter int CAP_CYCLES = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] LOAD_DATA,
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
  input  logic [CHAIN_LEN-1:0] EXPECT,
  input  logic [CHAIN_LEN-1:0] MASK,
  output logic                 MISMATCH,
`endif
  output logic                 SE,
  output logic                 SI,
  input  logic                 SO,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] UNLOAD_DATA
);

  // Wide enough for both the chain length and the capture count.
  localparam int LEN_W = $clog2(CHAIN_LEN + 1);
  localparam int CAP_W = $clog2(CAP_CYCLES + 1);
  localparam int CNT_W = (LEN_W > CAP_W) ? LEN_W : CAP_W;
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAP_CYCLES);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT_IN,
    S_CAPTURE,
    S_SHIFT_OUT
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] sr_q, sr_d;
  logic                 se_q, se_d;
  logic                 si_q, si_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CHAIN_LEN-1:0] unload_q, unload_d;
  logic [CHAIN_LEN-1:0] assembled;
  logic                 last_cnt;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic [CHAIN_LEN-1:0] mask_q, mask_d;
  logic                 mismatch_q, mismatch_d;
`endif

  // SO is the pre-edge Q of the tail flop; first sample lands in the MSB.
  assign assembled = {sr_q[CHAIN_LEN-2:0], SO};
  assign last_cnt  = (cnt_q == ONE_C);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    se_d     = se_q;
    si_d     = si_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unload_d = unload_q;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
    exp_d      = exp_q;
    mask_d     = mask_q;
    mismatch_d = mismatch_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (START) begin
          sr_d    = {LOAD_DATA[CHAIN_LEN-2:0], 1'b0};
          si_d    = LOAD_DATA[CHAIN_LEN-1];
          se_d    = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = LEN_C;
          state_d = S_SHIFT_IN;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
          exp_d  = EXPECT;
          mask_d = MASK;
`endif
        end
      end
      S_SHIFT_IN: begin
        cnt_d = cnt_q - ONE_C;
        if (last_cnt) begin
          se_d    = 1'b0;
          si_d    = 1'b0;
          cnt_d   = CAP_C;
          state_d = S_CAPTURE;
        end else begin
          si_d = sr_q[CHAIN_LEN-1];
          sr_d = sr_q << 1;
        end
      end
      S_CAPTURE: begin
        cnt_d = cnt_q - ONE_C;
        if (last_cnt) begin
          se_d    = 1'b1;
          si_d    = 1'b0;
          cnt_d   = LEN_C;
          state_d = S_SHIFT_OUT;
        end
      end
      S_SHIFT_OUT: begin
        // sr_q is all zeros after the load, so it doubles as the unload buffer.
        sr_d  = assembled;
        cnt_d = cnt_q - ONE_C;
        if (last_cnt) begin
          unload_d = assembled;
          se_d     = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          cnt_d    = '0;
          state_d  = S_IDLE;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
          mismatch_d = |((assembled ^ exp_q) & ~mask_q);
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        se_d    = 1'b0;
        si_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sr_q     <= '0;
      se_q     <= 1'b0;
      si_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      unload_q <= '0;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
      exp_q      <= '0;
      mask_q     <= '0;
      mismatch_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      se_q     <= se_d;
      si_q     <= si_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      unload_q <= unload_d;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
      exp_q      <= exp_d;
      mask_q     <= mask_d;
      mismatch_q <= mismatch_d;
`endif
    end
  end

  assign SE          = se_q;
  assign SI          = si_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign UNLOAD_DATA = unload_q;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
  assign MISMATCH    = mismatch_q;
`endif

endmodule
